core_lsu_ctrl: RTL and testbench
================================

CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning max REQ cycles before bus error (1..255).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port lsu_cmd_in  in  2  mem-stage command: 00 NONE, 01 LOAD (sign-extend), 10 LOADU (zero-extend), 11 STORE.
REQ-005 SHALL have port lsu_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-006 SHALL have port lsu_addr_in  in  32  byte address.
REQ-007 SHALL have port lsu_wdata_in  in  32  store data, right-aligned.
REQ-008 SHALL have port lsu_kill_in  in  1  mem-stage instruction killed by hazard control.
REQ-009 SHALL have port lsu_stall_out  out  1  stall request, wired to hazard control haz_stall_wb_in.
REQ-010 SHALL have port lsu_rdata_out  out  32  formatted load result.
REQ-011 SHALL have port lsu_rdata_vld_out  out  1  one-cycle load-result strobe.
REQ-012 SHALL have port lsu_misalign_out  out  1  one-cycle misaligned/reserved-size strobe.
REQ-013 SHALL have port lsu_bus_err_out  out  1  one-cycle bus-timeout strobe.
REQ-014 SHALL have port mem_req_out  out  1  bus request, held until ack.
REQ-015 SHALL have port mem_we_out  out  1  1 = write.
REQ-016 SHALL have port mem_addr_out  out  32  word address, bits[1:0] = 00.
REQ-017 SHALL have port mem_wdata_out  out  32  lane-replicated store data.
REQ-018 SHALL have port mem_be_out  out  4  byte enables.
REQ-019 SHALL have port mem_ack_in  in  1  bus ack; mem_rdata_in valid same cycle.
REQ-020 SHALL have port mem_rdata_in  in  32  bus read word.

Function
REQ-021 SHALL implement FSM IDLE, REQ, DONE; registered state.
REQ-022 IDLE: cmd!=NONE, aligned, kill=0 -> latch addr/we/be/wdata/cmd/offset, go REQ; lsu_stall_out=1 combinationally that cycle.
REQ-023 IDLE: cmd!=NONE, misaligned (half addr[0]=1, word addr[1:0]!=0, size 11), kill=0 -> lsu_misalign_out=1 same cycle, no bus request, no stall, stay IDLE.
REQ-024 IDLE with kill=1 or cmd=NONE SHALL issue nothing and keep stall=0.
REQ-025 REQ: mem_req_out=1, stall=1, bus outputs from latched values, stable until ack; on mem_ack_in -> capture formatted data, go DONE (min latency: issue cycle + ack cycle + DONE = 3 cycles).
REQ-026 DONE: stall=0 for exactly one cycle; LOAD/LOADU not killed -> lsu_rdata_vld_out=1; next state IDLE unconditionally (no new request accepted in DONE).
REQ-027 Kill during REQ SHALL NOT drop mem_req_out; result discarded (no vld in DONE).
REQ-028 REQ counter (8 bit) SHALL clear on entry; count reaching TIMEOUT_CYC without ack -> lsu_bus_err_out=1, drop req, go DONE, no vld.
REQ-029 Ack on the same cycle the counter reaches TIMEOUT_CYC SHALL win (normal completion, no error).
REQ-030 Byte enables: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111; reads use same be.
REQ-031 Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-032 Load: select lane by latched offset, sign-extend (LOAD) or zero-extend (LOADU) to 32 bits; lsu_rdata_out registered, holds until next load.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, clear counter/latches, lsu_rdata_out=0; all outputs 0 while in reset, including mid-REQ (req dropped immediately).
REQ-034 First request SHALL be accepted on the first cycle with rst_n=1.

Structure
REQ-035 Package core_lsu_pkg SHALL hold cmd and size encodings, FSM state typedef, TIMEOUT default.
REQ-036 Combinational lane logic (be, store replication, load extraction/extension) SHALL be sub-module lsu_data_align.

Verification
REQ-037 LOAD byte addr 0x103, ack after 2 REQ cycles, rdata 0x80FF_FFFF -> be 1000, addr 0x100, vld with 0xFFFF_FF80, stall high 3 cycles.
REQ-038 STORE half addr 0x202, wdata 0x1234_ABCD, immediate ack -> be 1100, wdata 0xABCD_ABCD, we=1, no vld.
REQ-039 LOAD word addr 0x101 -> misalign pulse, mem_req_out stays 0, stall 0.
REQ-040 LOADU half addr 0x4, kill asserted in REQ, rdata 0x0000_8001 -> req held to ack, no vld; zero-ext check w/o kill gives 0x0000_8001.
REQ-041 No ack, TIMEOUT_CYC=4 -> bus_err pulse after 4 REQ cycles, req dropped; rst_n=0 mid-REQ -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared encodings for the load/store unit controller.
//   - lsu_cmd_e   : mem-stage command encoding
//   - lsu_size_e  : access size encoding
//   - lsu_state_e : controller FSM state
//   - TIMEOUT_DEFAULT : default bus-timeout limit in REQ cycles
//   - is_misaligned() : alignment / reserved-size test on (size, addr[1:0])
package core_lsu_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,  // sign-extending load
    CMD_LOADU = 2'b10,  // zero-extending load
    CMD_STORE = 2'b11
  } lsu_cmd_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // The reserved size is treated as misaligned so it is rejected the same way.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational byte-lane logic for the LSU.
// Ports:
//   size      in  2   access size (byte/half/word; reserved gives be=0)
//   offset    in  2   byte offset within the word (addr[1:0])
//   sign_ext  in  1   1 = sign-extend the extracted load value
//   wdata     in  32  right-aligned store data
//   rdata     in  32  bus read word
//   be        out 4   byte enables for the access
//   wdata_rep out 32  store data replicated across all lanes
//   rdata_fmt out 32  selected load lane, extended to 32 bits
module lsu_data_align
  import core_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_fmt = 32'd0;

    case (offset)
      2'd0:    lane8 = rdata[7:0];
      2'd1:    lane8 = rdata[15:8];
      2'd2:    lane8 = rdata[23:16];
      default: lane8 = rdata[31:24];
    endcase
    lane16 = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_fmt = {{24{sign_ext & lane8[7]}}, lane8};
      end
      SIZE_HALF: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_fmt = {{16{sign_ext & lane16[15]}}, lane16};
      end
      SIZE_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_fmt = rdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_fmt = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/core_lsu_ctrl.sv
// core_lsu_ctrl: load/store unit controller between the mem stage and a
// simple request/ack memory bus.
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   lsu_cmd_in[1:0]       NONE / LOAD / LOADU / STORE
//   lsu_size_in[1:0]      byte / half / word / reserved
//   lsu_addr_in[31:0]     byte address
//   lsu_wdata_in[31:0]    right-aligned store data
//   lsu_kill_in           mem-stage instruction killed
//   lsu_stall_out         stall request to hazard control
//   lsu_rdata_out[31:0]   formatted load result (held until next load)
//   lsu_rdata_vld_out     one-cycle load-result strobe
//   lsu_misalign_out      one-cycle misaligned / reserved-size strobe
//   lsu_bus_err_out       one-cycle bus-timeout strobe
//   mem_req_out, mem_we_out, mem_addr_out[31:0], mem_wdata_out[31:0],
//   mem_be_out[3:0]       bus request side
//   mem_ack_in, mem_rdata_in[31:0]  bus response side
//
// Bus handshake: mem_req_out rises with we/addr/wdata/be already valid and all
// of them stay stable while mem_req_out is high. A transfer completes on the
// cycle mem_ack_in is high while mem_req_out is high; mem_rdata_in is valid in
// that same cycle. The request is withdrawn without ack only by timeout or reset.
module core_lsu_ctrl
  import core_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  lsu_cmd_in,
  input  logic [1:0]  lsu_size_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_wdata_in,
  input  logic        lsu_kill_in,
  output logic        lsu_stall_out,
  output logic [31:0] lsu_rdata_out,
  output logic        lsu_rdata_vld_out,
  output logic        lsu_misalign_out,
  output logic        lsu_bus_err_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_be_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

  lsu_state_e  state_q;
  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  cmd_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        killed_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        vld_q;
  logic        err_q;

  logic        cmd_valid;
  logic        addr_bad;
  logic        accept;
  logic        misalign;
  logic        in_req;
  logic [8:0]  cnt_nxt;
  logic [1:0]  sel_size;
  logic [1:0]  sel_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign cmd_valid = (lsu_cmd_in != CMD_NONE);
  assign addr_bad  = is_misaligned(lsu_size_in, lsu_addr_in[1:0]);
  assign accept    = (state_q == ST_IDLE) && cmd_valid && !addr_bad && !lsu_kill_in;
  assign misalign  = (state_q == ST_IDLE) && cmd_valid &&  addr_bad && !lsu_kill_in;
  assign cnt_nxt   = {1'b0, cnt_q} + 9'd1;

  // One align instance serves both directions: in IDLE it formats the incoming
  // store (be / replication), in REQ it formats the returning load word using
  // the latched size and offset.
  assign sel_size = (state_q == ST_IDLE) ? lsu_size_in       : size_q;
  assign sel_off  = (state_q == ST_IDLE) ? lsu_addr_in[1:0]  : off_q;

  lsu_data_align u_align (
    .size      (sel_size),
    .offset    (sel_off),
    .sign_ext  (cmd_q == CMD_LOAD),
    .wdata     (lsu_wdata_in),
    .rdata     (mem_rdata_in),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_fmt (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      cmd_q    <= '0;
      size_q   <= '0;
      off_q    <= '0;
      killed_q <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q   <= lsu_addr_in[31:2];
            we_q     <= (lsu_cmd_in == CMD_STORE);
            be_q     <= al_be;
            wdata_q  <= al_wdata;
            cmd_q    <= lsu_cmd_in;
            size_q   <= lsu_size_in;
            off_q    <= lsu_addr_in[1:0];
            killed_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A kill cannot abort the bus cycle; it only discards the result.
          if (lsu_kill_in) killed_q <= 1'b1;
          if (mem_ack_in) begin
            if ((cmd_q != CMD_STORE) && !killed_q && !lsu_kill_in) begin
              rdata_q <= al_rdata;
              vld_q   <= 1'b1;
            end
            state_q <= ST_DONE;
          end else if (cnt_nxt == TO_LIM) begin
            // Ack is checked first, so an ack in the limit cycle still completes.
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_nxt[7:0];
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst_n is low so a request in flight is
  // dropped in the very cycle reset is asserted.
  assign in_req            = rst_n && (state_q == ST_REQ);
  assign mem_req_out       = in_req;
  assign mem_we_out        = in_req && we_q;
  assign mem_addr_out      = in_req ? {addr_q, 2'b00} : 32'd0;
  assign mem_wdata_out     = in_req ? wdata_q : 32'd0;
  assign mem_be_out        = in_req ? be_q : 4'b0000;
  assign lsu_stall_out     = rst_n && (accept || (state_q == ST_REQ));
  assign lsu_misalign_out  = rst_n && misalign;
  assign lsu_rdata_vld_out = rst_n && vld_q;
  assign lsu_bus_err_out   = rst_n && err_q;
  assign lsu_rdata_out     = rst_n ? rdata_q : 32'd0;

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb_core_lsu_ctrl: scoreboard bench for core_lsu_ctrl (TIMEOUT_CYC = 4).
module tb_core_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  lsu_cmd_in;
  logic [1:0]  lsu_size_in;
  logic [31:0] lsu_addr_in;
  logic [31:0] lsu_wdata_in;
  logic        lsu_kill_in;
  logic        lsu_stall_out;
  logic [31:0] lsu_rdata_out;
  logic        lsu_rdata_vld_out;
  logic        lsu_misalign_out;
  logic        lsu_bus_err_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  core_lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .lsu_cmd_in        (lsu_cmd_in),
    .lsu_size_in       (lsu_size_in),
    .lsu_addr_in       (lsu_addr_in),
    .lsu_wdata_in      (lsu_wdata_in),
    .lsu_kill_in       (lsu_kill_in),
    .lsu_stall_out     (lsu_stall_out),
    .lsu_rdata_out     (lsu_rdata_out),
    .lsu_rdata_vld_out (lsu_rdata_vld_out),
    .lsu_misalign_out  (lsu_misalign_out),
    .lsu_bus_err_out   (lsu_bus_err_out),
    .mem_req_out       (mem_req_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .mem_be_out        (mem_be_out),
    .mem_ack_in        (mem_ack_in),
    .mem_rdata_in      (mem_rdata_in)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [68:0] bus_q[$];   // {we, be, addr, wdata}
  logic [34:0] res_q[$];   // {vld, misalign, bus_err, rdata}
  logic [31:0] last_load = 32'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: act=event exp=none", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_bad(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'd3) return 1'b1;
    n = 1 << size;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
    int n;
    logic [3:0] r;
    n = 1 << size;
    r = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    int n;
    logic [31:0] r;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [1:0] off,
                                             input logic sgn, input logic [31:0] rd);
    int n;
    logic [31:0] mask;
    logic [31:0] v;
    n = 1 << size;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v = (rd >> (8*off)) & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [68:0] act_bus;
    logic [68:0] cur_exp;
    logic        req_prev;
    logic [34:0] act_res;
    if (rst_n !== 1'b1) begin
      req_prev = 1'b0;
    end else begin
      if (mem_req_out) begin
        act_bus = {mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out};
        if (!req_prev) begin
          if (bus_q.size() == 0) flag("bus_unexpected");
          else begin
            cur_exp = bus_q.pop_front();
            check("bus_req", act_bus, cur_exp);
          end
        end else begin
          check("bus_stable", act_bus, cur_exp);
        end
      end
      if (lsu_rdata_vld_out || lsu_misalign_out || lsu_bus_err_out) begin
        act_res = {lsu_rdata_vld_out, lsu_misalign_out, lsu_bus_err_out,
                   lsu_rdata_vld_out ? lsu_rdata_out : 32'd0};
        if (res_q.size() == 0) flag("result_unexpected");
        else check("result", act_res, res_q.pop_front());
      end
      req_prev = mem_req_out;
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    lsu_cmd_in   = 2'b00;
    lsu_size_in  = 2'b00;
    lsu_addr_in  = 32'd0;
    lsu_wdata_in = 32'd0;
    lsu_kill_in  = 1'b0;
    mem_ack_in   = 1'b0;
    mem_rdata_in = 32'd0;
  endtask

  // Called at posedge+1 with the DUT idle. ack_dly: REQ cycle carrying the ack
  // (beyond TO means never acked); kill_cyc: REQ cycle with kill (0 = none).
  task automatic run_txn(input logic [1:0] cmd, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic kill_issue, input int ack_dly,
                         input int kill_cyc, input logic [31:0] rd);
    logic bad, active, killed, is_load;
    int   n_req, stall_cnt;
    logic [31:0] val;
    check("rdata_hold", lsu_rdata_out, last_load);
    lsu_cmd_in   = cmd;
    lsu_size_in  = size;
    lsu_addr_in  = addr;
    lsu_wdata_in = wd;
    lsu_kill_in  = kill_issue;
    bad     = model_bad(size, addr);
    active  = (cmd != 2'b00) && !kill_issue;
    is_load = (cmd == 2'b01) || (cmd == 2'b10);
    n_req   = (ack_dly < TO) ? ack_dly : TO;
    killed  = (kill_cyc >= 1) && (kill_cyc <= n_req);
    if (active && bad) res_q.push_back({3'b010, 32'd0});
    if (active && !bad) begin
      bus_q.push_back({cmd == 2'b11, model_be(size, addr[1:0]),
                       {addr[31:2], 2'b00}, model_wdata(size, wd)});
      if (ack_dly > TO) res_q.push_back({3'b001, 32'd0});
      else if (is_load && !killed) begin
        val = model_load(size, addr[1:0], cmd == 2'b01, rd);
        res_q.push_back({3'b100, val});
        last_load = val;
      end
    end
    @(negedge clk);
    stall_cnt = int'(lsu_stall_out);
    @(posedge clk); #1;
    idle_inputs();
    if (active && !bad) begin
      for (int i = 1; i <= n_req; i++) begin
        lsu_kill_in  = (i == kill_cyc);
        mem_ack_in   = (i == ack_dly);
        mem_rdata_in = (i == ack_dly) ? rd : $urandom;
        @(negedge clk);
        stall_cnt += int'(lsu_stall_out);
        @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);   // completion cycle: no stall, no request
      stall_cnt += int'(lsu_stall_out);
      check("done_req_low", mem_req_out, 1'b0);
      @(posedge clk); #1;
      check("stall_cycles", stall_cnt, 1 + n_req);
    end else begin
      check("stall_cycles", stall_cnt, 0);
    end
  endtask

  function automatic logic [105:0] all_outs();
    return {lsu_stall_out, lsu_rdata_out, lsu_rdata_vld_out, lsu_misalign_out,
            lsu_bus_err_out, mem_req_out, mem_we_out, mem_addr_out,
            mem_wdata_out, mem_be_out};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cmd, size;
    logic [31:0] addr;
    int ack_dly, kill_cyc;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 106'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases (first one issued in the first cycle out of reset).
    run_txn(2'b01, 2'b00, 32'h0000_0103, 32'h0,         1'b0, 2, 0, 32'h80FF_FFFF);
    run_txn(2'b11, 2'b01, 32'h0000_0202, 32'h1234_ABCD, 1'b0, 1, 0, 32'h0);
    run_txn(2'b01, 2'b10, 32'h0000_0101, 32'h0,         1'b0, 1, 0, 32'h0);
    run_txn(2'b10, 2'b01, 32'h0000_0004, 32'h0,         1'b0, 2, 1, 32'h0000_8001);
    run_txn(2'b10, 2'b01, 32'h0000_0004, 32'h0,         1'b0, 2, 0, 32'h0000_8001);
    run_txn(2'b01, 2'b10, 32'h0000_0010, 32'h0,         1'b0, TO + 1, 0, 32'h0);
    run_txn(2'b01, 2'b10, 32'h0000_0014, 32'h0,         1'b0, TO, 0, 32'hCAFE_F00D);
    run_txn(2'b01, 2'b11, 32'h0000_0020, 32'h0,         1'b0, 1, 0, 32'h0);
    run_txn(2'b01, 2'b10, 32'h0000_0024, 32'h0,         1'b1, 1, 0, 32'h1111_1111);
    run_txn(2'b00, 2'b10, 32'h0000_0028, 32'h0,         1'b0, 1, 0, 32'h0);
    run_txn(2'b01, 2'b01, 32'h0000_0032, 32'h0,         1'b0, 3, 0, 32'hFEDC_7654);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      cmd      = 2'($urandom_range(0, 3));
      size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr     = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = (size == 2'd0) ? addr[1:0] :
                                                 (size == 2'd1) ? {addr[1], 1'b0} : 2'b00;
      ack_dly  = $urandom_range(1, TO + 2);
      kill_cyc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0;
      run_txn(cmd, size, addr, $urandom, ($urandom_range(0, 9) == 0), ack_dly, kill_cyc, $urandom);
    end

    // Reset in the middle of a bus request.
    lsu_cmd_in  = 2'b01;
    lsu_size_in = 2'b10;
    lsu_addr_in = 32'h0000_0040;
    bus_q.push_back({1'b0, 4'b1111, 32'h0000_0040, 32'h0});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("mid_req_active", {mem_req_out, lsu_stall_out}, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_drops_req", all_outs(), 106'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_load = 32'd0;
    @(negedge clk);
    check("after_reset_idle", all_outs(), 106'd0);
    @(posedge clk); #1;
    run_txn(2'b01, 2'b00, 32'h0000_0051, 32'h0, 1'b0, 1, 0, 32'h0000_9C00);

    repeat (3) @(posedge clk);
    check("queues_empty", {32'(bus_q.size()), 32'(res_q.size())}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
